code_lock_param: RTL and testbench
==================================

# code_lock_param

Parametrised digit-entry combination lock, the next-generation core behind the TinyTapeout pad wrapper. Adds a configurable code length and digit width, a runtime-programmable code, a failed-attempt counter with timed lockout, and auto-relock after a fixed time. Outputs are Moore-decoded LED drives plus a state code for the pad byte.

## Interface
- DIGIT_W, 4: bits per digit.
- CODE_LEN, 4: digits per code.
- DEFAULT_CODE, 16'h1234: reset code.
  - Width DIGIT_W*CODE_LEN.
  - Most-significant digit is entered first.
- MAX_TRIES, 3: consecutive failures that trigger lockout (>=1).
- ERR_CYCLES, 8: dwell time in ERROR, in cycles (>=1).
- LOCKOUT_CYCLES, 1024: lockout duration, in cycles (>=1).
- UNLOCK_CYCLES, 256: auto-relock timeout, in cycles (>=1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_digit  in  DIGIT_W  digit sampled on an enter event.
- enter_btn  in  1  level input, already synchronised; a rising edge is one event.
- prog_btn  in  1  level input, already synchronised; a rising edge is one event.
- locked_led  out  1  high in LOCKED, ENTRY, ERROR, LOCKOUT.
- unlocked_led  out  1  high in UNLOCKED, PROGRAM.
- error_led  out  1  high in ERROR, LOCKOUT.
- lockout_led  out  1  high in LOCKOUT.
- state_leds  out  3  state encoding.
- fail_count  out  $clog2(MAX_TRIES+1)  consecutive failed attempts.

## Operation
- Edge detection: each of enter_btn and prog_btn has a flop.
  - Event = btn & ~btn_q.
  - A held button produces exactly one event.
- State encodings: LOCKED=000, ENTRY=001, UNLOCKED=010, ERROR=011, LOCKOUT=100, PROGRAM=101.
- LOCKED:
  - An enter event captures digit 0 and goes to ENTRY, with idx=1.
  - prog events are ignored.
- ENTRY:
  - Each enter event compares in_digit with code digit idx and ORs any mismatch into a sticky flag.
  - No early exit on mismatch: all CODE_LEN digits are always collected.
  - After the CODE_LEN-th digit, on a match: go to UNLOCKED, clear fail_count, load the unlock timer.
  - On a mismatch: increment fail_count.
    - If fail_count reaches MAX_TRIES: go to LOCKOUT and load LOCKOUT_CYCLES.
    - Otherwise: go to ERROR and load ERR_CYCLES.
  - CODE_LEN=1 goes directly from LOCKED to the verdict.
- ERROR: enter and prog events are ignored; on timer expiry go to LOCKED.
- LOCKOUT: all events are ignored; on expiry go to LOCKED and clear fail_count.
- UNLOCKED:
  - An enter event relocks immediately (LOCKED).
  - A prog event goes to PROGRAM with idx=0.
  - Timer expiry goes to LOCKED.
- PROGRAM:
  - Enter events write digits into a shadow register.
  - After the CODE_LEN-th digit, the shadow is committed to the code register in one cycle, and the state goes to LOCKED.
  - A prog event aborts: the code is unchanged, go to LOCKED.
  - No timeout applies in PROGRAM.
- Simultaneous enter and prog events: prog wins in UNLOCKED and PROGRAM; elsewhere prog is ignored.
- fail_count saturates at MAX_TRIES and is never reported above it.

## Timing
- Reset values:
  - State LOCKED; outputs locked_led=1, all other LEDs 0, state_leds=000, fail_count=0.
  - Code register = DEFAULT_CODE; idx, mismatch flag, timers and edge flops = 0.
- Reset mid-entry or mid-programming:
  - The partial entry is discarded.
  - A programmed code reverts to DEFAULT_CODE; the code register is volatile.
- Latency:
  - A button rising at edge t is seen as an event in cycle t.
  - The state and outputs update at edge t+1.
  - The verdict appears one cycle after the final digit's event.
- Timers: the count loads on state entry. The state is held for exactly N cycles, then exits on the next edge.
  - ERROR = ERR_CYCLES cycles.
  - LOCKOUT = LOCKOUT_CYCLES cycles.
  - UNLOCKED = at most UNLOCK_CYCLES cycles.
- Commit is atomic: a match check in the cycle after PROGRAM exit uses the new code.
- All outputs are decoded from registered state only, with no input-to-output combinational path.

## Structure
- Shared package lock_pkg holds:
  - the state enum and its 3-bit encodings;
  - the LED decode function.
- Sub-module lock_timer:
  - Load/down-counter with done output.
  - Width $clog2 of the maximum of the three cycle parameters.
  - One shared instance; states never overlap.
- Top FSM holds the code register, shadow register, idx counter, mismatch flag, fail counter and edge flops.

## Test plan
Bench parameters: CODE_LEN=4, DIGIT_W=4, DEFAULT_CODE=16'h1234, MAX_TRIES=3, ERR_CYCLES=4, LOCKOUT_CYCLES=16, UNLOCK_CYCLES=32.
- Enter 1,2,3,4 -> unlocked_led=1 and state_leds=010 one cycle after the 4th event; auto-relock to LOCKED after 32 cycles.
- Enter 1,2,3,5 -> state ERROR for 4 cycles with error_led=1 and fail_count=1, then LOCKED; enter_btn presses during ERROR are ignored.
- Three wrong codes -> LOCKOUT with lockout_led=1 and fail_count=3; presses are ignored for 16 cycles, then LOCKED with fail_count=0.
- Unlock, prog event, enter 9,8,7,6 -> LOCKED:
  - code 1234 now fails;
  - code 9876 unlocks;
  - after reset, 1234 unlocks again.
- Held enter_btn across 10 cycles -> exactly one digit captured. Reset asserted after two digits -> LOCKED, and a fresh 1,2,3,4 unlocks.
- Enter and prog events in the same cycle while UNLOCKED -> enters PROGRAM; a prog event after two new digits aborts, and code 1234 is still valid.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the parametrised code lock: state encodings, LED
// decode and a small constant helper used to size the shared timer.
package lock_pkg;

    typedef enum logic [2:0] {
        S_LOCKED   = 3'b000,
        S_ENTRY    = 3'b001,
        S_UNLOCKED = 3'b010,
        S_ERROR    = 3'b011,
        S_LOCKOUT  = 3'b100,
        S_PROGRAM  = 3'b101
    } state_e;

    // Plain-vector aliases so the FSM register can stay a logic [2:0].
    localparam logic [2:0] ST_LOCKED   = 3'(S_LOCKED);
    localparam logic [2:0] ST_ENTRY    = 3'(S_ENTRY);
    localparam logic [2:0] ST_UNLOCKED = 3'(S_UNLOCKED);
    localparam logic [2:0] ST_ERROR    = 3'(S_ERROR);
    localparam logic [2:0] ST_LOCKOUT  = 3'(S_LOCKOUT);
    localparam logic [2:0] ST_PROGRAM  = 3'(S_PROGRAM);

    typedef struct packed {
        logic locked;
        logic unlocked;
        logic error;
        logic lockout;
    } led_t;

    function automatic led_t led_decode(input logic [2:0] st);
        led_t leds;
        leds = '0;
        case (st)
            ST_LOCKED, ST_ENTRY: leds.locked = 1'b1;
            ST_ERROR: begin
                leds.locked = 1'b1;
                leds.error  = 1'b1;
            end
            ST_LOCKOUT: begin
                leds.locked  = 1'b1;
                leds.error   = 1'b1;
                leds.lockout = 1'b1;
            end
            ST_UNLOCKED, ST_PROGRAM: leds.unlocked = 1'b1;
            // Unused encodings recover to LOCKED on the next edge; show them as locked.
            default: leds.locked = 1'b1;
        endcase
        return leds;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/code_lock_param_if.sv
// Pad-side bundle of the code lock: digit/button inputs and LED/state outputs.
// master drives the buttons (wrapper or bench), slave is the lock core.
interface code_lock_param_if #(
    parameter int DIGIT_W = 4,
    parameter int FAIL_W  = 2
);
    logic [DIGIT_W-1:0] in_digit;
    logic               enter_btn;
    logic               prog_btn;
    logic               locked_led;
    logic               unlocked_led;
    logic               error_led;
    logic               lockout_led;
    logic [2:0]         state_leds;
    logic [FAIL_W-1:0]  fail_count;

    modport master (
        output in_digit, enter_btn, prog_btn,
        input  locked_led, unlocked_led, error_led, lockout_led, state_leds, fail_count
    );

    modport slave (
        input  in_digit, enter_btn, prog_btn,
        output locked_led, unlocked_led, error_led, lockout_led, state_leds, fail_count
    );
endinterface

// File: rtl/lock_timer.sv
// Load/down-counter shared by the timed states. Loaded with N-1 on state entry,
// done is high in the N-th cycle so the owner leaves on the following edge.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);
endmodule

// File: rtl/code_lock_param.sv
// Digit-entry combination lock with programmable code, failure counting,
// timed lockout and auto-relock. All outputs decode from registered state.
module code_lock_param
    import lock_pkg::*;
#(
    parameter int                           DIGIT_W        = 4,
    parameter int                           CODE_LEN       = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0]  DEFAULT_CODE   = 16'h1234,
    parameter int                           MAX_TRIES      = 3,
    parameter int                           ERR_CYCLES     = 8,
    parameter int                           LOCKOUT_CYCLES = 1024,
    parameter int                           UNLOCK_CYCLES  = 256
) (
    input  logic              clk,
    input  logic              reset,
    code_lock_param_if.slave  bus
);
    localparam int CW      = DIGIT_W * CODE_LEN;
    localparam int IW      = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FW      = $clog2(MAX_TRIES + 1);
    localparam int MAX_CYC = max3(ERR_CYCLES, LOCKOUT_CYCLES, UNLOCK_CYCLES);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] ERR_LOAD     = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_TRIES);

    logic [2:0]    state_q,  state_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic          mis_q,    mis_d;
    logic [FW-1:0] fail_q,   fail_d;
    logic [CW-1:0] code_q,   code_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic          enter_q;
    logic          prog_q;

    logic          enter_ev;
    logic          prog_ev;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          verdict;
    logic          verdict_mis;
    led_t          leds;

    assign enter_ev = bus.enter_btn & ~enter_q;
    assign prog_ev  = bus.prog_btn  & ~prog_q;

    // Digit view of the code register, most-significant digit = index 0.
    logic [DIGIT_W-1:0] code_dig [CODE_LEN];
    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_code_dig
        assign code_dig[gi] = code_q[CW-1-gi*DIGIT_W -: DIGIT_W];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mis_d       = mis_q;
        fail_d      = fail_q;
        code_d      = code_q;
        shadow_d    = shadow_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        verdict     = 1'b0;
        verdict_mis = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (enter_ev) begin
                    if (CODE_LEN == 1) begin
                        verdict     = 1'b1;
                        verdict_mis = (bus.in_digit != code_dig[0]);
                    end else begin
                        state_d = ST_ENTRY;
                        idx_d   = IW'(1);
                        mis_d   = (bus.in_digit != code_dig[0]);
                    end
                end
            end
            ST_ENTRY: begin
                // Mismatches are only accumulated; the verdict waits for the last digit.
                if (enter_ev) begin
                    if (idx_q == LAST_IDX) begin
                        verdict     = 1'b1;
                        verdict_mis = mis_q | (bus.in_digit != code_dig[idx_q]);
                    end else begin
                        idx_d = idx_q + 1'b1;
                        mis_d = mis_q | (bus.in_digit != code_dig[idx_q]);
                    end
                end
            end
            ST_ERROR: begin
                if (tmr_done) state_d = ST_LOCKED;
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end
            end
            ST_UNLOCKED: begin
                if (prog_ev) begin
                    state_d = ST_PROGRAM;
                    idx_d   = '0;
                end else if (enter_ev || tmr_done) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_PROGRAM: begin
                if (prog_ev) begin
                    state_d = ST_LOCKED;
                end else if (enter_ev) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (idx_q == IW'(i)) shadow_d[CW-1-i*DIGIT_W -: DIGIT_W] = bus.in_digit;
                    end
                    // The final digit is merged and committed in the same edge.
                    if (idx_q == LAST_IDX) begin
                        code_d  = shadow_d;
                        state_d = ST_LOCKED;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOCKED;
        endcase

        if (verdict) begin
            if (!verdict_mis) begin
                state_d  = ST_UNLOCKED;
                fail_d   = '0;
                tmr_load = 1'b1;
                tmr_val  = UNLOCK_LOAD;
            end else if (fail_q >= FAIL_MAX - 1'b1) begin
                state_d  = ST_LOCKOUT;
                fail_d   = FAIL_MAX;
                tmr_load = 1'b1;
                tmr_val  = LOCKOUT_LOAD;
            end else begin
                state_d  = ST_ERROR;
                fail_d   = fail_q + 1'b1;
                tmr_load = 1'b1;
                tmr_val  = ERR_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOCKED;
            idx_q    <= '0;
            mis_q    <= 1'b0;
            fail_q   <= '0;
            code_q   <= DEFAULT_CODE;
            shadow_q <= '0;
            enter_q  <= 1'b0;
            prog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mis_q    <= mis_d;
            fail_q   <= fail_d;
            code_q   <= code_d;
            shadow_q <= shadow_d;
            enter_q  <= bus.enter_btn;
            prog_q   <= bus.prog_btn;
        end
    end

    lock_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign leds             = led_decode(state_q);
    assign bus.locked_led   = leds.locked;
    assign bus.unlocked_led = leds.unlocked;
    assign bus.error_led    = leds.error;
    assign bus.lockout_led  = leds.lockout;
    assign bus.state_leds   = state_q;
    assign bus.fail_count   = fail_q;
endmodule

// File: tb/tb_code_lock_param.sv
// Directed bench for code_lock_param: a vector table of button operations with
// expected state/fail_count, plus hand-written held-button and reset sequences.
module tb_code_lock_param;
    localparam logic [2:0] SL = 3'b000;
    localparam logic [2:0] SE = 3'b001;
    localparam logic [2:0] SU = 3'b010;
    localparam logic [2:0] SR = 3'b011;
    localparam logic [2:0] SK = 3'b100;
    localparam logic [2:0] SP = 3'b101;

    typedef enum int {OP_ENT, OP_PRG, OP_BOTH, OP_IDLE, OP_RST} op_e;

    typedef struct {
        op_e        op;
        int         val;
        logic [2:0] st;
        logic [1:0] fc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    code_lock_param_if #(.DIGIT_W(4), .FAIL_W(2)) bus ();

    code_lock_param #(
        .DIGIT_W        (4),
        .CODE_LEN       (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_TRIES      (3),
        .ERR_CYCLES     (4),
        .LOCKOUT_CYCLES (16),
        .UNLOCK_CYCLES  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {locked, unlocked, error, lockout} expected for each state code.
    function automatic logic [3:0] exp_leds(input logic [2:0] st);
        case (st)
            3'b000, 3'b001: return 4'b1000;
            3'b011:         return 4'b1010;
            3'b100:         return 4'b1011;
            3'b010, 3'b101: return 4'b0100;
            default:        return 4'b0000;
        endcase
    endfunction

    function automatic vec_t mk(input op_e op, input int val, input logic [2:0] st, input logic [1:0] fc);
        vec_t v;
        v.op  = op;
        v.val = val;
        v.st  = st;
        v.fc  = fc;
        return v;
    endfunction

    task automatic check(input string tag, input logic [2:0] st, input logic [1:0] fc);
        logic [3:0] got_leds;
        got_leds = {bus.locked_led, bus.unlocked_led, bus.error_led, bus.lockout_led};
        checks++;
        if (bus.state_leds !== st) begin
            failures++;
            $display("FAIL %s state_leds got=%b want=%b", tag, bus.state_leds, st);
        end
        checks++;
        if (bus.fail_count !== fc) begin
            failures++;
            $display("FAIL %s fail_count got=%0d want=%0d", tag, bus.fail_count, fc);
        end
        checks++;
        if (got_leds !== exp_leds(st)) begin
            failures++;
            $display("FAIL %s leds(l,u,e,k) got=%b want=%b", tag, got_leds, exp_leds(st));
        end
        $display("%s: state=%b fail=%0d leds=%b", tag, bus.state_leds, bus.fail_count, got_leds);
    endtask

    task automatic press(input logic ent, input logic prg, input logic [3:0] d);
        @(negedge clk);
        bus.in_digit  = d;
        bus.enter_btn = ent;
        bus.prog_btn  = prg;
        @(negedge clk);
        bus.enter_btn = 1'b0;
        bus.prog_btn  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(1'b1, 1'b0, code[i*4 +: 4]);
    endtask

    initial begin
        bus.in_digit  = '0;
        bus.enter_btn = 1'b0;
        bus.prog_btn  = 1'b0;

        // Correct code, then auto-relock at exactly 32 cycles.
        vecs.push_back(mk(OP_ENT, 1, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 2, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 3, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 4, SU, 2'd0));
        vecs.push_back(mk(OP_IDLE, 31, SU, 2'd0));
        vecs.push_back(mk(OP_IDLE, 1, SL, 2'd0));
        // prog ignored in LOCKED; wrong code -> ERROR for 4 cycles, presses ignored.
        vecs.push_back(mk(OP_PRG, 0, SL, 2'd0));
        vecs.push_back(mk(OP_ENT, 1, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 2, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 3, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 5, SR, 2'd1));
        vecs.push_back(mk(OP_ENT, 1, SR, 2'd1));
        vecs.push_back(mk(OP_IDLE, 1, SR, 2'd1));
        vecs.push_back(mk(OP_IDLE, 1, SL, 2'd1));
        // Second and third failures -> LOCKOUT for 16 cycles.
        vecs.push_back(mk(OP_ENT, 9, SE, 2'd1));
        vecs.push_back(mk(OP_ENT, 9, SE, 2'd1));
        vecs.push_back(mk(OP_ENT, 9, SE, 2'd1));
        vecs.push_back(mk(OP_ENT, 9, SR, 2'd2));
        vecs.push_back(mk(OP_IDLE, 4, SL, 2'd2));
        vecs.push_back(mk(OP_ENT, 1, SE, 2'd2));
        vecs.push_back(mk(OP_ENT, 2, SE, 2'd2));
        vecs.push_back(mk(OP_ENT, 3, SE, 2'd2));
        vecs.push_back(mk(OP_ENT, 0, SK, 2'd3));
        vecs.push_back(mk(OP_ENT, 1, SK, 2'd3));
        vecs.push_back(mk(OP_PRG, 0, SK, 2'd3));
        vecs.push_back(mk(OP_IDLE, 11, SK, 2'd3));
        vecs.push_back(mk(OP_IDLE, 1, SL, 2'd0));
        // Program 9876, old code fails, new code unlocks, reset restores 1234.
        vecs.push_back(mk(OP_ENT, 1, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 2, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 3, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 4, SU, 2'd0));
        vecs.push_back(mk(OP_PRG, 0, SP, 2'd0));
        vecs.push_back(mk(OP_ENT, 9, SP, 2'd0));
        vecs.push_back(mk(OP_ENT, 8, SP, 2'd0));
        vecs.push_back(mk(OP_ENT, 7, SP, 2'd0));
        vecs.push_back(mk(OP_ENT, 6, SL, 2'd0));
        vecs.push_back(mk(OP_ENT, 1, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 2, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 3, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 4, SR, 2'd1));
        vecs.push_back(mk(OP_IDLE, 4, SL, 2'd1));
        vecs.push_back(mk(OP_ENT, 9, SE, 2'd1));
        vecs.push_back(mk(OP_ENT, 8, SE, 2'd1));
        vecs.push_back(mk(OP_ENT, 7, SE, 2'd1));
        vecs.push_back(mk(OP_ENT, 6, SU, 2'd0));
        vecs.push_back(mk(OP_ENT, 0, SL, 2'd0));
        vecs.push_back(mk(OP_RST, 2, SL, 2'd0));
        vecs.push_back(mk(OP_ENT, 1, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 2, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 3, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 4, SU, 2'd0));
        // Enter+prog together while UNLOCKED -> PROGRAM; prog aborts, code unchanged.
        vecs.push_back(mk(OP_BOTH, 7, SP, 2'd0));
        vecs.push_back(mk(OP_ENT, 5, SP, 2'd0));
        vecs.push_back(mk(OP_ENT, 6, SP, 2'd0));
        vecs.push_back(mk(OP_PRG, 0, SL, 2'd0));
        // Enter+prog together while LOCKED: prog ignored, digit captured.
        vecs.push_back(mk(OP_BOTH, 1, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 2, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 3, SE, 2'd0));
        vecs.push_back(mk(OP_ENT, 4, SU, 2'd0));
        vecs.push_back(mk(OP_ENT, 0, SL, 2'd0));

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset", SL, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_ENT:  press(1'b1, 1'b0, 4'(vecs[i].val));
                OP_PRG:  press(1'b0, 1'b1, 4'd0);
                OP_BOTH: press(1'b1, 1'b1, 4'(vecs[i].val));
                OP_IDLE: repeat (vecs[i].val) @(negedge clk);
                default: do_reset(vecs[i].val);
            endcase
            check($sformatf("vec%0d %s %0d", i, vecs[i].op.name(), vecs[i].val), vecs[i].st, vecs[i].fc);
        end

        // Held enter for 10 cycles captures exactly one digit.
        @(negedge clk);
        bus.in_digit  = 4'd1;
        bus.enter_btn = 1'b1;
        repeat (10) @(negedge clk);
        bus.enter_btn = 1'b0;
        check("held_enter", SE, 2'd0);
        press(1'b1, 1'b0, 4'd2);
        press(1'b1, 1'b0, 4'd3);
        press(1'b1, 1'b0, 4'd4);
        check("held_then_234", SU, 2'd0);
        press(1'b1, 1'b0, 4'd0);
        check("held_relock", SL, 2'd0);

        // Reset mid-entry discards partial digits and the failure count.
        enter_code(16'h1111);
        check("wrong_before_rst", SR, 2'd1);
        repeat (4) @(negedge clk);
        press(1'b1, 1'b0, 4'd1);
        press(1'b1, 1'b0, 4'd2);
        check("two_digits", SE, 2'd1);
        do_reset(2);
        check("mid_entry_rst", SL, 2'd0);
        enter_code(16'h1234);
        check("fresh_1234", SU, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
